// File: rtl/arc4_phase_sched.sv
// arc4_phase_sched
//
// Runs the three ARC4 phases (S-array init, KSA, PRGA) in order for each
// accepted start request. Each phase is started through the sub-block's
// rdy/en handshake. The scheduler also owns the single S memory port and
// grants it to one phase at a time.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   en / rdy                     start request / idle flag (en sampled when rdy=1)
//   key                          key, latched when en is accepted
//   done                         one-cycle pulse after PRGA completes
//   phase                        0 idle, 1 init, 2 ksa, 3 prga
//   init_en, ksa_en, prga_en     one-cycle start pulses to the sub-blocks
//   init_rdy, ksa_rdy, prga_rdy  sub-block idle flags
//   ksa_key, prga_key            latched key
//   {init,ksa,prga}_addr/_wrdata/_wren   requester S memory signals
//   s_addr, s_wrdata, s_wren     S memory port (driven by the current owner)
//   s_rddata / s_rddata_out      S memory read data, passed to all requesters
module arc4_phase_sched #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int KEY_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  input  logic [KEY_W-1:0]  key,
  output logic              done,
  output logic [1:0]        phase,
  output logic              init_en,
  output logic              ksa_en,
  output logic              prga_en,
  input  logic              init_rdy,
  input  logic              ksa_rdy,
  input  logic              prga_rdy,
  output logic [KEY_W-1:0]  ksa_key,
  output logic [KEY_W-1:0]  prga_key,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] init_wrdata,
  input  logic [DATA_W-1:0] ksa_wrdata,
  input  logic [DATA_W-1:0] prga_wrdata,
  input  logic              init_wren,
  input  logic              ksa_wren,
  input  logic              prga_wren,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wrdata,
  output logic              s_wren,
  input  logic [DATA_W-1:0] s_rddata,
  output logic [DATA_W-1:0] s_rddata_out
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ST_INIT = 3'd1,
    S_WT_INIT = 3'd2,
    S_ST_KSA  = 3'd3,
    S_WT_KSA  = 3'd4,
    S_ST_PRGA = 3'd5,
    S_WT_PRGA = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INIT = 2'd1,
    OWN_KSA  = 2'd2,
    OWN_PRGA = 2'd3
  } owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic              busy_seen_q, busy_seen_d;
  logic              done_q, done_d;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      key_q       <= '0;
      busy_seen_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      key_q       <= key_d;
      busy_seen_q <= busy_seen_d;
      done_q      <= done_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // A WT_x state only exits once the sub-block has been seen busy and then
  // idle again; this keeps a sub-block that is slow to drop rdy after its
  // en pulse from being mistaken for an already finished one.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    busy_seen_d = busy_seen_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          key_d   = key;
          state_d = S_ST_INIT;
        end
      end
      S_ST_INIT: begin
        if (init_rdy) begin
          state_d     = S_WT_INIT;
          busy_seen_d = 1'b0;
        end
      end
      S_WT_INIT: begin
        if (busy_seen_q && init_rdy) begin
          state_d = S_ST_KSA;
        end else if (!init_rdy) begin
          busy_seen_d = 1'b1;
        end
      end
      S_ST_KSA: begin
        if (ksa_rdy) begin
          state_d     = S_WT_KSA;
          busy_seen_d = 1'b0;
        end
      end
      S_WT_KSA: begin
        if (busy_seen_q && ksa_rdy) begin
          state_d = S_ST_PRGA;
        end else if (!ksa_rdy) begin
          busy_seen_d = 1'b1;
        end
      end
      S_ST_PRGA: begin
        if (prga_rdy) begin
          state_d     = S_WT_PRGA;
          busy_seen_d = 1'b0;
        end
      end
      S_WT_PRGA: begin
        if (busy_seen_q && prga_rdy) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (!prga_rdy) begin
          busy_seen_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Ownership is taken on entry to ST_x and kept through WT_x, so it is
    // derived from the state being entered.
    case (state_d)
      S_ST_INIT, S_WT_INIT: owner_d = OWN_INIT;
      S_ST_KSA,  S_WT_KSA:  owner_d = OWN_KSA;
      S_ST_PRGA, S_WT_PRGA: owner_d = OWN_PRGA;
      default:              owner_d = OWN_NONE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    rdy     = (state_q == S_IDLE);
    done    = done_q;
    init_en = (state_q == S_ST_INIT) && init_rdy;
    ksa_en  = (state_q == S_ST_KSA)  && ksa_rdy;
    prga_en = (state_q == S_ST_PRGA) && prga_rdy;

    case (state_q)
      S_ST_INIT, S_WT_INIT: phase = 2'd1;
      S_ST_KSA,  S_WT_KSA:  phase = 2'd2;
      S_ST_PRGA, S_WT_PRGA: phase = 2'd3;
      default:              phase = 2'd0;
    endcase

    ksa_key      = key_q;
    prga_key     = key_q;
    s_rddata_out = s_rddata;

    // Unregistered port mux: the owner's signals reach the memory in the
    // same cycle; every other requester is ignored.
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    case (owner_q)
      OWN_INIT: begin
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
        s_wren   = init_wren;
      end
      OWN_KSA: begin
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
        s_wren   = ksa_wren;
      end
      OWN_PRGA: begin
        s_addr   = prga_addr;
        s_wrdata = prga_wrdata;
        s_wren   = prga_wren;
      end
      default: begin
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_arc4_phase_sched.sv
// Testbench for arc4_phase_sched: behavioural init/ksa/prga stubs, an S
// memory model, and a reference of the expected memory contents built from
// the stubs' randomized write lists.
module tb_arc4_phase_sched;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int KW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [KW-1:0] key = '0;

  logic          rdy, done, init_en, ksa_en, prga_en;
  logic [1:0]    phase;
  logic          init_rdy, ksa_rdy, prga_rdy;
  logic [KW-1:0] ksa_key, prga_key;
  logic [AW-1:0] init_addr, ksa_addr, prga_addr, s_addr;
  logic [DW-1:0] init_wrdata, ksa_wrdata, prga_wrdata, s_wrdata;
  logic          init_wren, ksa_wren, prga_wren, s_wren;
  logic [DW-1:0] s_rddata, s_rddata_out;

  int total = 0;
  int bad   = 0;

  arc4_phase_sched #(.ADDR_W(AW), .DATA_W(DW), .KEY_W(KW)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key), .done(done),
    .phase(phase), .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
    .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
    .ksa_key(ksa_key), .prga_key(prga_key),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
    .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata), .prga_wrdata(prga_wrdata),
    .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .s_rddata(s_rddata), .s_rddata_out(s_rddata_out)
  );

  always #5 clk = ~clk;

  // S memory: synchronous write, registered read
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (s_wren) mem[s_addr] <= s_wrdata;
    s_rddata <= mem[s_addr];
  end

  // init stub: writes s[i]=i for i=0..255, one per busy cycle
  logic       init_busy = 1'b0;
  logic [8:0] init_cnt  = '0;
  logic       init_rogue = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      init_busy <= 1'b0;
      init_cnt  <= '0;
    end else if (init_busy) begin
      if (init_cnt == 9'd255) init_busy <= 1'b0;
      init_cnt <= init_cnt + 9'd1;
    end else if (init_en) begin
      init_busy <= 1'b1;
      init_cnt  <= '0;
    end
  end
  assign init_rdy    = !init_busy;
  assign init_wren   = init_busy || init_rogue;
  assign init_addr   = init_rogue ? 8'h05 : init_cnt[7:0];
  assign init_wrdata = init_rogue ? 8'hFF : init_cnt[7:0];

  // ksa / prga stubs: busy for *_len cycles, writing a random list
  logic [7:0] ksa_len = 8'd20, prga_len = 8'd20;
  logic       ksa_busy = 1'b0, prga_busy = 1'b0, ksa_hold = 1'b0;
  logic [7:0] ksa_cnt = '0, prga_cnt = '0;
  logic [7:0] ksa_a [128], ksa_d [128], prga_a [128], prga_d [128];
  logic       ksa_w [128], prga_w [128];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ksa_busy <= 1'b0;
      ksa_cnt  <= '0;
    end else if (ksa_busy) begin
      if (ksa_cnt == ksa_len - 8'd1) ksa_busy <= 1'b0;
      ksa_cnt <= ksa_cnt + 8'd1;
    end else if (ksa_en) begin
      ksa_busy <= 1'b1;
      ksa_cnt  <= '0;
    end
  end
  assign ksa_rdy    = !ksa_busy && !ksa_hold;
  assign ksa_wren   = ksa_busy && ksa_w[ksa_cnt[6:0]];
  assign ksa_addr   = ksa_a[ksa_cnt[6:0]];
  assign ksa_wrdata = ksa_d[ksa_cnt[6:0]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      prga_busy <= 1'b0;
      prga_cnt  <= '0;
    end else if (prga_busy) begin
      if (prga_cnt == prga_len - 8'd1) prga_busy <= 1'b0;
      prga_cnt <= prga_cnt + 8'd1;
    end else if (prga_en) begin
      prga_busy <= 1'b1;
      prga_cnt  <= '0;
    end
  end
  assign prga_rdy    = !prga_busy;
  assign prga_wren   = prga_busy && prga_w[prga_cnt[6:0]];
  assign prga_addr   = prga_a[prga_cnt[6:0]];
  assign prga_wrdata = prga_d[prga_cnt[6:0]];

  // Event monitor: pulse counts, cycle stamps, phase history
  int cyc = 0, acc_cyc = 0, init_en_cyc = 0, ksa_en_cyc = 0, prga_en_cyc = 0, done_cyc = 0;
  int init_rise_cyc = 0, ksa_rise_cyc = 0, prga_rise_cyc = 0;
  int n_init = 0, n_ksa = 0, n_prga = 0, n_done = 0;
  logic init_rdy_p = 1'b1, ksa_rdy_p = 1'b1, prga_rdy_p = 1'b1;
  logic [1:0] last_ph = 2'd0;
  logic [1:0] ph_q [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (en && rdy) acc_cyc <= cyc;
    if (init_en) begin n_init <= n_init + 1; init_en_cyc <= cyc; end
    if (ksa_en)  begin n_ksa  <= n_ksa  + 1; ksa_en_cyc  <= cyc; end
    if (prga_en) begin n_prga <= n_prga + 1; prga_en_cyc <= cyc; end
    if (done)    begin n_done <= n_done + 1; done_cyc    <= cyc; end
    if (init_rdy && !init_rdy_p) init_rise_cyc <= cyc;
    if (ksa_rdy  && !ksa_rdy_p)  ksa_rise_cyc  <= cyc;
    if (prga_rdy && !prga_rdy_p) prga_rise_cyc <= cyc;
    init_rdy_p <= init_rdy;
    ksa_rdy_p  <= ksa_rdy;
    prga_rdy_p <= prga_rdy;
    if (phase != last_ph) ph_q.push_back(phase);
    last_ph <= phase;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdy"},     32'(rdy), 32'd1);
    chk({tag, "_phase"},   32'(phase), 32'd0);
    chk({tag, "_done"},    32'(done), 32'd0);
    chk({tag, "_ens"},     32'({init_en, ksa_en, prga_en}), 32'd0);
    chk({tag, "_s_wren"},  32'(s_wren), 32'd0);
    chk({tag, "_s_addr"},  32'(s_addr), 32'd0);
    chk({tag, "_s_wrdata"}, 32'(s_wrdata), 32'd0);
    chk({tag, "_key"},     32'(ksa_key), 32'd0);
  endtask

  task automatic wait_phase(input logic [1:0] p, input int budget);
    int n = 0;
    @(negedge clk);
    while (phase !== p && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_phase", 32'(phase), 32'(p));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done", 32'(done), 32'd1);
  endtask

  task automatic start_run(input logic [KW-1:0] k);
    @(negedge clk);
    en  = 1'b1;
    key = k;
    @(negedge clk);
    en  = 1'b0;
  endtask

  logic [7:0]    exp_mem [256];
  logic [15:0]   ph_seq;
  logic [KW-1:0] k_run;
  int            nbad, n0;

  initial begin
    for (int i = 0; i < 128; i++) begin
      ksa_a[i]  = 8'($urandom_range(16, 255));
      ksa_d[i]  = 8'($urandom);
      ksa_w[i]  = 1'($urandom);
      prga_a[i] = 8'($urandom_range(16, 255));
      prga_d[i] = 8'($urandom);
      prga_w[i] = 1'($urandom);
    end
    for (int i = 0; i < 256; i++) mem[i] = 8'hAA;

    // Reference: init pattern, then the KSA writes, then the PRGA writes.
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i);
    for (int k = 0; k < 20; k++) if (ksa_w[k])  exp_mem[ksa_a[k]]  = ksa_d[k];
    for (int k = 0; k < 20; k++) if (prga_w[k]) exp_mem[prga_a[k]] = prga_d[k];

    // Power-on reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("por");
    rst = 1'b0;

    // Run 1: full run, isolation and busy-ignore
    ph_q.delete();
    start_run(24'h00033C);
    chk("acc_rdy",     32'(rdy), 32'd0);
    chk("acc_phase",   32'(phase), 32'd1);
    chk("acc_init_en", 32'(init_en), 32'd1);
    chk("mux_init_wren", 32'(s_wren), 32'(init_wren));

    wait_phase(2'd2, 400);
    nbad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 8'(i)) nbad++;
    chk("init_mem_bad_entries", 32'(nbad), 32'd0);
    chk("ksa_en_first", 32'(ksa_en), 32'd1);
    chk("ksa_key", 32'(ksa_key), 32'h00033C);

    init_rogue = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      chk("mux_ksa_wren", 32'(s_wren), 32'(ksa_wren));
      chk("mux_ksa_addr", 32'(s_addr), 32'(ksa_addr));
      chk("mux_ksa_data", 32'(s_wrdata), 32'(ksa_wrdata));
      if (k == 2) begin
        en  = 1'b1;
        key = 24'h123456;
      end else begin
        en = 1'b0;
      end
      @(negedge clk);
    end
    en = 1'b0;
    chk("busy_ksa_key",  32'(ksa_key), 32'h00033C);
    chk("busy_prga_key", 32'(prga_key), 32'h00033C);
    chk("busy_phase",    32'(phase), 32'd2);

    wait_phase(2'd3, 100);
    init_rogue = 1'b0;
    chk("prga_en_first", 32'(prga_en), 32'd1);
    chk("prga_key", 32'(prga_key), 32'h00033C);

    wait_done(100);
    chk("done_rdy",   32'(rdy), 32'd1);
    chk("done_phase", 32'(phase), 32'd0);
    init_rogue = 1'b1;
    #1;
    chk("idle_s_wren",   32'(s_wren), 32'd0);
    chk("idle_s_addr",   32'(s_addr), 32'd0);
    chk("idle_s_wrdata", 32'(s_wrdata), 32'd0);
    init_rogue = 1'b0;
    @(negedge clk);
    chk("done_width", 32'(done), 32'd0);
    chk("n_init", 32'(n_init), 32'd1);
    chk("n_ksa",  32'(n_ksa),  32'd1);
    chk("n_prga", 32'(n_prga), 32'd1);
    chk("n_done", 32'(n_done), 32'd1);
    ph_seq = '0;
    foreach (ph_q[i]) ph_seq = {ph_seq[13:0], ph_q[i]};
    chk("phase_count", 32'(ph_q.size()), 32'd4);
    chk("phase_seq",   32'(ph_seq), 32'h006C);
    chk("lat_accept_init_en", 32'(init_en_cyc - acc_cyc), 32'd1);
    chk("gap_init_ksa",       32'(ksa_en_cyc - init_rise_cyc), 32'd1);
    chk("gap_ksa_prga",       32'(prga_en_cyc - ksa_rise_cyc), 32'd1);
    chk("gap_prga_done",      32'(done_cyc - prga_rise_cyc), 32'd1);
    nbad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) nbad++;
    chk("final_mem_bad_entries", 32'(nbad), 32'd0);
    chk("mem5_kept", 32'(mem[5]), 32'd5);
    chk("rddata_fanout", 32'(s_rddata_out), 32'(s_rddata));

    // Run 2: reset in the middle of a long KSA, then restart
    ksa_len = 8'd100;
    k_run   = 24'($urandom);
    start_run(k_run);
    wait_phase(2'd2, 400);
    repeat (50) @(negedge clk);
    #3 rst = 1'b1;
    #1 chk_reset("mid_ksa");
    @(negedge clk);
    rst     = 1'b0;
    ksa_len = 8'd20;
    n0      = n_init;
    k_run   = 24'($urandom);
    start_run(k_run);
    chk("restart_init_en", 32'(init_en), 32'd1);
    chk("restart_phase",   32'(phase), 32'd1);
    wait_done(800);
    chk("restart_n_init", 32'(n_init - n0), 32'd1);
    chk("restart_key",    32'(prga_key), 32'(k_run));

    // Run 3: KSA sub-block not ready for 10 cycles after init completes
    ksa_hold = 1'b1;
    n0       = n_ksa;
    k_run    = 24'($urandom);
    start_run(k_run);
    wait_phase(2'd2, 400);
    for (int k = 0; k < 10; k++) begin
      chk("hold_phase",  32'(phase), 32'd2);
      chk("hold_ksa_en", 32'(ksa_en), 32'd0);
      @(negedge clk);
    end
    ksa_hold = 1'b0;
    #1 chk("release_ksa_en", 32'(ksa_en), 32'd1);
    @(negedge clk);
    chk("after_release_ksa_en", 32'(ksa_en), 32'd0);
    chk("after_release_phase",  32'(phase), 32'd2);
    wait_done(200);
    chk("hold_n_ksa", 32'(n_ksa - n0), 32'd1);
    chk("hold_key",   32'(ksa_key), 32'(k_run));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arc4_phase_sched.md
# arc4_phase_sched

Sequencer and S-memory arbiter for the ARC4 datapath. On one start request it runs the three ARC4 phases in order (S-array init, key-scheduling KSA, keystream generation/decrypt PRGA), each through the sub-block's rdy/en handshake. It grants the single-port 256x8 S memory to exactly one phase at a time. It sits between the top level (switches/keys) and the init/ksa/prga sub-blocks, and owns the S memory port.

## Interface
- ADDR_W, 8, S memory address width (256 entries)
- DATA_W, 8, S memory data width
- KEY_W, 24, key width
- clk  in  1  system clock (CLOCK_50 at top)
- rst  in  1  asynchronous active-high reset
- en  in  1  start request; sampled only when rdy=1
- rdy  out  1  1 = idle, will accept en
- key  in  KEY_W  key; latched when en accepted
- done  out  1  one-cycle pulse when PRGA completes
- phase  out  2  0 idle, 1 init, 2 ksa, 3 prga (for LEDR)
- init_en / ksa_en / prga_en  out  1 each  one-cycle start pulses to sub-blocks
- init_rdy / ksa_rdy / prga_rdy  in  1 each  sub-block idle flags
- ksa_key, prga_key  out  KEY_W each  latched key
- {init,ksa,prga}_addr  in  ADDR_W  requester S address
- {init,ksa,prga}_wrdata  in  DATA_W  requester write data
- {init,ksa,prga}_wren  in  1  requester write enable
- s_addr  out  ADDR_W  to S memory
- s_wrdata  out  DATA_W  to S memory
- s_wren  out  1  to S memory
- s_rddata  in  DATA_W  from S memory; fanned out unchanged as s_rddata_out (out, DATA_W) to all requesters

## Operation
- States: IDLE, ST_INIT, WT_INIT, ST_KSA, WT_KSA, ST_PRGA, WT_PRGA.
- IDLE: rdy=1, phase=0. On en=1, latch key into key_q and go to ST_INIT.
- ST_x: if x_rdy=1, assert x_en for exactly this cycle and go to WT_x. Otherwise hold with x_en=0 until x_rdy=1.
- WT_x: busy_seen is cleared on entry and set when x_rdy=0 is sampled. Leave when busy_seen=1 and x_rdy=1.
  - WT_INIT goes to ST_KSA.
  - WT_KSA goes to ST_PRGA.
  - WT_PRGA goes to IDLE with done=1 for that one cycle.
- Ownership register owner ∈ {NONE, INIT, KSA, PRGA}:
  - Set on entry to ST_x and held through WT_x.
  - Set to NONE in IDLE.
- S port mux is combinational from owner.
  - NONE: s_addr=0, s_wrdata=0, s_wren=0.
  - Non-owner wren/addr/wrdata are ignored completely.
- ksa_key and prga_key are driven from key_q. key changes while busy have no effect.
- en while rdy=0 is ignored; no queuing.
- phase = 1/2/3 while in the init/ksa/prga state pair, else 0.

## Timing
- Reset (asynchronous, immediate): state IDLE, rdy=1, done=0, phase=0, all x_en=0, owner NONE, s_wren=0, s_addr=0, s_wrdata=0, key_q=0, busy_seen=0.
- Reset mid-phase aborts the run. The sub-blocks are reset by the same rst. The next accepted en restarts from init.
- Accept cycle: en=1 and rdy=1 at edge t. At t+1: rdy=0, state ST_INIT.
- Earliest init_en is high in cycle t+1, when init_rdy=1 already.
- Phase-to-phase gap is one cycle:
  - x_rdy is seen high in WT_x at edge u.
  - ST_next is active at u+1.
  - next_en is high at u+1 if next_rdy=1.
- Done: done=1 and rdy=1 in the same cycle following the PRGA completion edge. A new en is accepted in that cycle.
- Mux adds no register stage: s_* follow the owner's signals combinationally in the same cycle.
- s_rddata latency is defined by the memory; the scheduler adds none.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> immediately rdy=1, phase=0, s_wren=0, done=0, all x_en=0.
- Full run with behavioural stubs:
  - Stimulus: init stub writes s[i]=i for i=0..255; ksa/prga stubs are busy 20 cycles each; key=24'h00033C.
  - Required: exactly one init_en, one ksa_en and one prga_en pulse, in order. phase steps 1→2→3→0. One done pulse, then rdy=1. After WT_INIT exits, S memory holds mem[i]==i for all 256 entries. ksa_key=prga_key=24'h00033C.
- Isolation: during KSA the init stub drives init_wren=1, addr 8'h05, data 8'hFF -> s_wren, s_addr and s_wrdata track only the ksa_* inputs. mem[5] stays 5 unless KSA writes it.
- Busy-ignore: pulse en and change key to 24'h123456 during WT_KSA -> no extra init_en, and ksa_key/prga_key stay 24'h00033C.
- Reset mid-KSA: assert rst at cycle 50 of the KSA phase -> all outputs return to reset values. A new en runs init again (init_en pulses once).
- Delayed sub rdy: hold ksa_rdy=0 for 10 cycles after init completes -> state stays ST_KSA, ksa_en=0, and ksa_en pulses in the first cycle ksa_rdy=1.
